led_status_seq: RTL and testbench

Status sequencer that drives the LED blink stage on the TinyFPGA BX current logger. It turns logger events (error, activity, logging active) into a single prioritised status. It presents that status to the blink stage as a blink enable plus a prescale exponent. Every status change forces a one-cycle enable gap, so the blink stage restarts its divider cleanly at the new rate.

---
 rtl/led_status_pkg.sv | 16 +
 rtl/led_status_seq_hold_timer.sv | 37 +++
 rtl/led_status_seq.sv | 88 ++++++++
 tb/tb_led_status_seq.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/led_status_pkg.sv
// Shared definitions for the LED status sequencer.
// Holds the status encoding and the default blink prescale exponents.
package led_status_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOG  = 2'd1,
        ST_ACT  = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    localparam int unsigned DEF_P_LOG = 23;
    localparam int unsigned DEF_P_ACT = 21;
    localparam int unsigned DEF_P_ERR = 19;

endpackage

// File: rtl/led_status_seq_hold_timer.sv
// Retriggerable saturating down-counter for the activity hold.
// Ports: i_clk, i_rst (async, high), i_load (reload to CYCLES),
// o_active (post-update count is nonzero, i.e. valid for this edge).
module hold_timer #(
    parameter int unsigned CYCLES = 16_000_000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_load,
    output logic o_active
);

    localparam int unsigned W = $clog2(CYCLES + 1);

    logic [W-1:0] hold_q;
    logic [W-1:0] hold_d;

    always_comb begin
        hold_d = hold_q;
        if (i_load)
            hold_d = W'(CYCLES);
        else if (hold_q != '0)
            hold_d = hold_q - 1'b1;
    end

    // Exposes the value the counter is about to take, so the
    // priority logic sees the post-update hold in the same cycle.
    assign o_active = (hold_d != '0);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            hold_q <= '0;
        else
            hold_q <= hold_d;
    end

endmodule

// File: rtl/led_status_seq.sv
// Status sequencer: prioritises error/activity/logging into a blink
// enable and prescale exponent, forcing a 1-cycle enable gap on change.
// Ports: i_clk, i_rst (async, high), i_evt_err, i_err_clr, i_evt_act,
// i_logging in; o_blink_en, o_clk_prescale, o_state out.
module led_status_seq
    import led_status_pkg::*;
#(
    parameter int unsigned PRESCALE_W      = 5,
    parameter int unsigned P_LOG           = DEF_P_LOG,
    parameter int unsigned P_ACT           = DEF_P_ACT,
    parameter int unsigned P_ERR           = DEF_P_ERR,
    parameter int unsigned ACT_HOLD_CYCLES = 16_000_000
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_evt_err,
    input  logic                  i_err_clr,
    input  logic                  i_evt_act,
    input  logic                  i_logging,
    output logic                  o_blink_en,
    output logic [PRESCALE_W-1:0] o_clk_prescale,
    output logic [1:0]            o_state
);

    localparam logic [PRESCALE_W-1:0] PL = PRESCALE_W'(P_LOG);
    localparam logic [PRESCALE_W-1:0] PA = PRESCALE_W'(P_ACT);
    localparam logic [PRESCALE_W-1:0] PE = PRESCALE_W'(P_ERR);

    logic                  err_q;
    logic                  err_d;
    logic                  hold_act;
    state_t                st_q;
    state_t                st_d;
    logic                  blink_d;
    logic [PRESCALE_W-1:0] pre_d;

    hold_timer #(
        .CYCLES (ACT_HOLD_CYCLES)
    ) u_hold (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_load   (i_evt_act),
        .o_active (hold_act)
    );

    always_comb begin
        // Set dominates clear.
        err_d = i_evt_err | (err_q & ~i_err_clr);

        st_d = ST_IDLE;
        priority case (1'b1)
            err_d:     st_d = ST_ERR;
            hold_act:  st_d = ST_ACT;
            i_logging: st_d = ST_LOG;
            default:   st_d = ST_IDLE;
        endcase

        // IDLE keeps the last rate so the divider is not disturbed.
        pre_d = o_clk_prescale;
        case (st_d)
            ST_LOG:  pre_d = PL;
            ST_ACT:  pre_d = PA;
            ST_ERR:  pre_d = PE;
            default: pre_d = o_clk_prescale;
        endcase

        // Any change drops the enable for a cycle so the blink
        // stage restarts at the new rate.
        blink_d = (st_d == st_q) && (st_d != ST_IDLE);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            err_q          <= 1'b0;
            st_q           <= ST_IDLE;
            o_blink_en     <= 1'b0;
            o_clk_prescale <= PL;
        end else begin
            err_q          <= err_d;
            st_q           <= st_d;
            o_blink_en     <= blink_d;
            o_clk_prescale <= pre_d;
        end
    end

    assign o_state = st_q;

endmodule

// File: tb/tb_led_status_seq.sv
// Self-checking bench for led_status_seq with an 8-cycle hold.
// Directed literal checks, then random bursts against a behavioural model.
module tb_led_status_seq;

    localparam int HOLD = 8;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_evt_err = 1'b0;
    logic       i_err_clr = 1'b0;
    logic       i_evt_act = 1'b0;
    logic       i_logging = 1'b0;
    logic       o_blink_en;
    logic [4:0] o_clk_prescale;
    logic [1:0] o_state;

    int errors = 0;
    int checks = 0;

    led_status_seq #(
        .ACT_HOLD_CYCLES (HOLD)
    ) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_evt_err      (i_evt_err),
        .i_err_clr      (i_err_clr),
        .i_evt_act      (i_evt_act),
        .i_logging      (i_logging),
        .o_blink_en     (o_blink_en),
        .o_clk_prescale (o_clk_prescale),
        .o_state        (o_state)
    );

    always #5 i_clk = ~i_clk;

    // Behavioural model: error flag, cycles of activity left,
    // status from priority, rate per status, enable per history.
    bit m_err;
    int m_left;
    int m_st;
    int m_pre;
    bit m_en;

    function automatic int rate(int s, int keep);
        if (s == 3) return 19;
        if (s == 2) return 21;
        if (s == 1) return 23;
        return keep;
    endfunction

    always @(posedge i_clk or posedge i_rst) begin
        int nst;
        if (i_rst) begin
            m_err = 0; m_left = 0; m_st = 0; m_pre = 23; m_en = 0;
        end else begin
            if (i_evt_act) m_left = HOLD;
            else if (m_left > 0) m_left = m_left - 1;
            if (i_evt_err) m_err = 1;
            else if (i_err_clr) m_err = 0;
            if (m_err) nst = 3;
            else if (m_left > 0) nst = 2;
            else if (i_logging) nst = 1;
            else nst = 0;
            m_en = (nst == m_st) && (nst != 0);
            m_pre = rate(nst, m_pre);
            m_st = nst;
        end
    end

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d @%0t", name, act, exp, $time);
        end
    endtask

    // Continuous compare against the model, plus gap invariants.
    logic [1:0] p_st = 2'd0;
    logic       p_en = 1'b0;
    logic [4:0] p_pre = 5'd23;
    always @(negedge i_clk) begin
        chk("model_state", int'(o_state), m_st);
        chk("model_blink", int'(o_blink_en), int'(m_en));
        chk("model_presc", int'(o_clk_prescale), m_pre);
        if (o_state != p_st)
            chk("gap_on_change", int'(o_blink_en), 0);
        if (o_blink_en && p_en)
            chk("presc_stable", int'(o_clk_prescale), int'(p_pre));
        p_st  <= o_state;
        p_en  <= o_blink_en;
        p_pre <= o_clk_prescale;
    end

    task automatic tick(bit e, bit c, bit a, bit l);
        i_evt_err = e; i_err_clr = c; i_evt_act = a; i_logging = l;
        @(posedge i_clk);
        #1;
        i_evt_err = 0; i_err_clr = 0; i_evt_act = 0;
    endtask

    task automatic outs(string n, int s, int en, int pre);
        chk({n, "_state"}, int'(o_state), s);
        chk({n, "_blink"}, int'(o_blink_en), en);
        chk({n, "_presc"}, int'(o_clk_prescale), pre);
    endtask

    initial begin
        bit lg;
        repeat (3) @(posedge i_clk);
        #1;
        outs("reset", 0, 0, 23);
        i_rst = 0;

        tick(0, 0, 0, 1);
        outs("log_on", 1, 0, 23);
        tick(0, 0, 0, 1);
        outs("log_on_k1", 1, 1, 23);
        tick(0, 0, 0, 0);
        outs("log_off", 0, 0, 23);
        tick(0, 0, 0, 1);
        tick(0, 0, 0, 1);

        tick(0, 0, 1, 1);
        outs("act_k", 2, 0, 21);
        for (int i = 1; i < HOLD; i++) begin
            tick(0, 0, 0, 1);
            outs("act_hold", 2, 1, 21);
        end
        tick(0, 0, 0, 1);
        outs("act_end", 1, 0, 23);
        tick(0, 0, 0, 1);

        tick(0, 0, 1, 1);
        for (int i = 1; i < 5; i++) tick(0, 0, 0, 1);
        tick(0, 0, 1, 1);
        outs("retrig", 2, 1, 21);
        for (int i = 6; i < 13; i++) tick(0, 0, 0, 1);
        outs("retrig_last", 2, 1, 21);
        tick(0, 0, 0, 1);
        outs("retrig_end", 1, 0, 23);

        tick(0, 0, 1, 1);
        tick(0, 0, 0, 1);
        tick(1, 0, 0, 1);
        outs("err_set", 3, 0, 19);
        tick(0, 0, 0, 1);
        outs("err_hold", 3, 1, 19);
        tick(1, 1, 0, 1);
        outs("err_setclr", 3, 1, 19);
        tick(0, 1, 1, 1);
        outs("err_clr_act", 2, 0, 21);
        for (int i = 0; i < HOLD + 2; i++) tick(0, 0, 0, 0);
        outs("idle_keep", 0, 0, 21);

        tick(0, 0, 1, 1);
        tick(0, 0, 0, 1);
        #2;
        i_rst = 1;
        #1;
        outs("async_rst", 0, 0, 23);
        @(negedge i_clk);
        i_rst = 0;
        tick(0, 0, 0, 0);
        outs("post_rst", 0, 0, 23);

        lg = 0;
        for (int n = 0; n < 10000; n++) begin
            if ($urandom_range(0, 49) == 0) lg = ~lg;
            tick($urandom_range(0, 39) == 0,
                 $urandom_range(0, 19) == 0,
                 $urandom_range(0, 14) == 0, lg);
        end

        @(negedge i_clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
